// File: rtl/diff_freq_serial_in.sv
// Tick-timed serial receiver: samples an idle-low line at mid-bit and rebuilds
// DATA_BIT-bit words LSB first, framed by a shared i_start strobe.
module diff_freq_serial_in #(
  parameter int DATA_BIT     = 16,
  parameter int TICK_PER_BIT = 16,
  parameter int TICK_DIV     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_repeat,
  input  logic                i_serial,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_valid,
  output logic                o_busy
);

  localparam int TICK_W = (TICK_PER_BIT > 1) ? $clog2(TICK_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(TICK_PER_BIT / 2);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BIT - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_sync_p0;
  logic                r_sync_p1;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [DATA_BIT-1:0] r_shift;
  logic                r_done;
  logic                w_tick;

  // Right shift with the new bit entering at the MSB; safe for DATA_BIT == 1.
  function automatic logic [DATA_BIT-1:0] shift_in(input logic [DATA_BIT-1:0] cur,
                                                   input logic bit_in);
    return (cur >> 1) | (DATA_BIT'(bit_in) << (DATA_BIT - 1));
  endfunction

  assign w_tick = (r_state == S_RECV) && (r_div_cnt == DIV_LAST);

  // Stage p0/p1: two-flop synchronizer, reset to the idle-low line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= i_serial;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Frame FSM; the completed word is published one cycle after the last-bit tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_done     <= 1'b0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      r_done  <= 1'b0;
      if (r_done) begin
        o_data  <= r_shift;
        o_valid <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          o_busy <= 1'b0;
          if (i_start && !i_stop) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= S_RECV;
            o_busy     <= 1'b1;
          end
        end
        S_RECV: begin
          if (i_stop) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end else begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
              if (r_tick_cnt == TICK_MID) begin
                r_shift <= shift_in(r_shift, r_sync_p1);
              end
              if (r_tick_cnt == TICK_LAST) begin
                r_tick_cnt <= '0;
                if (r_bit_cnt == BIT_LAST) begin
                  r_bit_cnt <= '0;
                  r_div_cnt <= '0;
                  r_done    <= 1'b1;
                  if (!i_repeat) begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                  end
                end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                end
              end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// Directed bench for diff_freq_serial_in with default parameters
// (16 bits, 16 ticks/bit, 2 clocks/tick -> 32 clocks per bit).
module tb_diff_freq_serial_in;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_repeat = 1'b0;
  logic        i_serial = 1'b0;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_busy;

  int total = 0;
  int bad = 0;

  int          vcnt;
  int          vk[2];
  logic [15:0] vd[2];
  logic        busy100;
  logic        busy513;

  typedef struct {
    string       name;
    logic [15:0] w0;
    logic [15:0] w1;
    int          nwords;
    int          rep;
    int          stop_k;
    int          restart_k;
    int          nclk;
    int          exp_cnt;
    int          exp_k0;
    logic [15:0] exp_d0;
    int          exp_k1;
    logic [15:0] exp_d1;
    logic [15:0] exp_end_data;
    logic        exp_busy513;
  } vec_t;

  vec_t tbl[8];

  diff_freq_serial_in #(
    .DATA_BIT(16),
    .TICK_PER_BIT(16),
    .TICK_DIV(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_stop  (i_stop),
    .i_repeat(i_repeat),
    .i_serial(i_serial),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // k counts clocks after the edge that accepts i_start; outputs are observed
  // on the negedge after edge k and inputs set there are seen by edge k+1.
  task automatic run_frame(input logic [15:0] w0, input logic [15:0] w1, input int nwords,
                           input int rep, input int stop_k, input int restart_k, input int nclk);
    logic [15:0] cur;
    vcnt = 0;
    vk[0] = -1;
    vk[1] = -1;
    vd[0] = '0;
    vd[1] = '0;
    busy100 = 1'b0;
    busy513 = 1'b0;
    @(negedge clk);
    i_start  = 1'b1;
    i_serial = 1'b0;
    @(posedge clk);
    for (int k = 0; k < nclk; k++) begin
      @(negedge clk);
      if (o_valid) begin
        if (vcnt < 2) begin
          vk[vcnt] = k;
          vd[vcnt] = o_data;
        end
        vcnt++;
      end
      if (k == 100) busy100 = o_busy;
      if (k == 513) busy513 = o_busy;
      cur = (k / 512 == 0) ? w0 : w1;
      i_serial = (k < nwords * 512) ? cur[(k % 512) / 32] : 1'b0;
      i_stop   = (k + 1 == stop_k);
      i_start  = (k + 1 == restart_k);
      i_repeat = (rep != 0) && (k < 900);
    end
    i_stop   = 1'b0;
    i_start  = 1'b0;
    i_repeat = 1'b0;
    i_serial = 1'b0;
  endtask

  initial begin
    logic [15:0] wv;
    logic        seen_busy;
    logic        seen_valid;

    tbl[0] = '{"basic",      16'hA5C3, 16'h0000, 1, 0,  -1,  -1,  560, 1, 513, 16'hA5C3, -1, 16'h0000, 16'hA5C3, 1'b0};
    tbl[1] = '{"all_low",    16'h0000, 16'h0000, 1, 0,  -1,  -1,  560, 1, 513, 16'h0000, -1, 16'h0000, 16'h0000, 1'b0};
    tbl[2] = '{"all_high",   16'hFFFF, 16'h0000, 1, 0,  -1,  -1,  560, 1, 513, 16'hFFFF, -1, 16'h0000, 16'hFFFF, 1'b0};
    tbl[3] = '{"pre_abort",  16'h00FF, 16'h0000, 1, 0,  -1,  -1,  560, 1, 513, 16'h00FF, -1, 16'h0000, 16'h00FF, 1'b0};
    tbl[4] = '{"abort_b7",   16'h5555, 16'h0000, 1, 0, 229,  -1,  560, 0,  -1, 16'h0000, -1, 16'h0000, 16'h00FF, 1'b0};
    tbl[5] = '{"restart",    16'h5555, 16'h0000, 1, 0,  -1, 300,  560, 1, 513, 16'h5555, -1, 16'h0000, 16'h5555, 1'b0};
    tbl[6] = '{"stop_last",  16'h1234, 16'h0000, 1, 0, 512,  -1,  560, 0,  -1, 16'h0000, -1, 16'h0000, 16'h5555, 1'b0};
    tbl[7] = '{"repeat",     16'h1234, 16'hBEEF, 2, 1,  -1,  -1, 1100, 2, 513, 16'h1234, 1025, 16'hBEEF, 16'hBEEF, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset o_data", o_data, 16'h0000);
    check("reset o_valid", o_valid, 1'b0);
    check("reset o_busy", o_busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].w0, tbl[i].w1, tbl[i].nwords, tbl[i].rep,
                tbl[i].stop_k, tbl[i].restart_k, tbl[i].nclk);
      check($sformatf("%s valid_count", tbl[i].name), vcnt, tbl[i].exp_cnt);
      check($sformatf("%s busy_mid", tbl[i].name), busy100, 1'b1);
      check($sformatf("%s busy_513", tbl[i].name), busy513, tbl[i].exp_busy513);
      check($sformatf("%s end_data", tbl[i].name), o_data, tbl[i].exp_end_data);
      check($sformatf("%s end_busy", tbl[i].name), o_busy, 1'b0);
      if (tbl[i].exp_cnt >= 1) begin
        check($sformatf("%s valid0_clk", tbl[i].name), vk[0], tbl[i].exp_k0);
        check($sformatf("%s valid0_data", tbl[i].name), vd[0], tbl[i].exp_d0);
      end
      if (tbl[i].exp_cnt >= 2) begin
        check($sformatf("%s valid1_clk", tbl[i].name), vk[1], tbl[i].exp_k1);
        check($sformatf("%s valid1_data", tbl[i].name), vd[1], tbl[i].exp_d1);
      end
    end

    // Simultaneous i_start and i_stop in IDLE: no frame starts
    @(negedge clk);
    i_start = 1'b1;
    i_stop  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_stop  = 1'b0;
    seen_busy  = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      seen_busy  = seen_busy | o_busy;
      seen_valid = seen_valid | o_valid;
      @(negedge clk);
    end
    check("both_strobes busy", seen_busy, 1'b0);
    check("both_strobes valid", seen_valid, 1'b0);

    // Reset asserted at bit 9 of a frame
    wv = 16'hABCD;
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 298; k++) begin
      @(negedge clk);
      i_start  = 1'b0;
      i_serial = wv[k / 32];
    end
    check("pre_reset busy", o_busy, 1'b1);
    check("pre_reset data", o_data, 16'hBEEF);
    rst_n = 1'b0;
    #1;
    check("midreset o_data", o_data, 16'h0000);
    check("midreset o_valid", o_valid, 1'b0);
    check("midreset o_busy", o_busy, 1'b0);
    i_serial = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(16'h3C5A, 16'h0000, 1, 0, -1, -1, 560);
    check("after_reset valid_count", vcnt, 1);
    check("after_reset valid0_clk", vk[0], 513);
    check("after_reset valid0_data", vd[0], 16'h3C5A);
    check("after_reset end_busy", o_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
